wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back stage directly upstream of the 32-entry register file. It owns that file's single write port (rd, rd_din, reg_write).
- It merges two result sources:
  - the in-order pipeline (MEM/WB), which is never stalled by this block;
  - a long-latency unit (LU, e.g. a multi-cycle mul/div), whose results are buffered in a small FIFO.
- It keeps a per-register pending scoreboard so issue logic can interlock on outstanding LU destinations.

Parameters:
- REG_WIDTH, 64, data width of results and register-file write data.
- BUF_DEPTH, 2, LU result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive cycles an LU result may wait at the FIFO head before the pipeline is asked to hold off.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pipe_valid  input  1  pipeline result present this cycle.
- pipe_reg_write  input  1  pipeline result writes a register.
- pipe_rd  input  5  pipeline destination register.
- pipe_data  input  REG_WIDTH  pipeline result.
- lu_valid  input  1  LU result offered.
- lu_ready  output  1  FIFO can accept; transfer when lu_valid&&lu_ready.
- lu_rd  input  5  LU destination register.
- lu_data  input  REG_WIDTH  LU result.
- iss_valid  input  1  an LU op is issued this cycle.
- iss_rd  input  5  destination register of the issued LU op.
- pend_mask  output  32  bit i=1 means x[i] awaits an LU result.
- stall_pipe  output  1  request that upstream present no register write next cycle.
- rd  output  5  register-file destination.
- rd_din  output  REG_WIDTH  register-file write data.
- reg_write  output  1  register-file write enable.

Behaviour:
- Reset state: reg_write=0, rd=0, rd_din=0, pend_mask=0, stall_pipe=0, FIFO empty, starvation counter=0.
  - lu_ready=0 while reset is high.
  - Reset mid-operation discards buffered results and pending bits.
- pipe_win = pipe_valid && pipe_reg_write && pipe_rd!=0.
- Per-cycle arbitration (decided in cycle t, outputs registered into t+1):
  1. If pipe_win: rd<=pipe_rd, rd_din<=pipe_data, reg_write<=1. The pipeline always wins, even while stall_pipe=1.
  2. Else if FIFO is non-empty: pop the head.
     - If head rd!=0: drive rd/rd_din from the head with reg_write<=1.
     - If head rd=0: pop with reg_write<=0.
  3. Else: reg_write<=0. rd and rd_din hold their previous values.
- Latency:
  - pipeline result at t produces reg_write at t+1;
  - an LU result accepted at t produces reg_write at t+2 at the earliest (no FIFO bypass).
- FIFO:
  - lu_ready = !full (combinational from count, gated by reset).
  - Push and pop in the same cycle leave count unchanged; order is strictly FIFO.
  - Pointers wrap modulo BUF_DEPTH.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and is not popped.
  - It clears on a pop or when the FIFO is empty.
  - stall_pipe is registered: it goes to 1 the cycle after the counter reaches STARVE_LIMIT and stays 1 until the cycle after the next pop.
- Scoreboard:
  - iss_valid with iss_rd!=0 sets bit iss_rd; iss_rd=0 is ignored.
  - A pop of an LU entry with rd!=0 clears bit rd in the same edge as the write is registered.
  - Set and clear of the same bit in one cycle: set wins.
  - Issuing to an already-pending rd is an upstream protocol violation. The result is undefined; the bench must not drive it.
- x0 is never written from either source.
- Upstream guarantees that no pipeline write targets a pending register. The block does not check this.

Test Plan:
- Reset for 2 cycles, then idle → reg_write=0, pend_mask=0, lu_ready=1 in the first cycle after reset.
- Pipeline write rd=5, data=0xA5 at t, with nothing buffered → rd=5, rd_din=0xA5, reg_write=1 at t+1 only.
- iss_valid rd=7 at t0, then LU result rd=7, data=0x1234 at t1 with pipe idle → reg_write rd=7 at t1+2; pend_mask[7] goes 1 after t0 and 0 after the pop edge.
- Fill the FIFO with rd=8 and rd=9 while pipe_win holds every cycle → lu_ready=0 once two entries are held; stall_pipe=1 after STARVE_LIMIT waiting cycles. Then drop pipe_valid → writes rd=8, then rd=9, in order; stall_pipe returns to 0; lu_ready returns to 1.
- LU result and pipe_rd=0 write in the same cycle → no x0 write; the LU entry pops the next cycle.
- Assert reset while the FIFO holds one entry and pend_mask[3]=1 → after reset, FIFO empty, pend_mask=0, no stale reg_write.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the register-file write port, merging in-order
// pipeline results with buffered long-latency unit (LU) results, and keeps a
// pending scoreboard of outstanding LU destinations for issue interlocks.
module wb_arbiter #(
  parameter int REG_WIDTH    = 64,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_valid,
  input  logic                 pipe_reg_write,
  input  logic [4:0]           pipe_rd,
  input  logic [REG_WIDTH-1:0] pipe_data,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [4:0]           lu_rd,
  input  logic [REG_WIDTH-1:0] lu_data,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  output logic [31:0]          pend_mask,
  output logic                 stall_pipe,
  output logic [4:0]           rd,
  output logic [REG_WIDTH-1:0] rd_din,
  output logic                 reg_write
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  logic [4:0]           buf_rd   [BUF_DEPTH];
  logic [REG_WIDTH-1:0] buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [STV_W-1:0]     starve_cnt;

  logic        pipe_win, fifo_empty, push, pop;
  logic [4:0]  head_rd;
  logic [31:0] set_mask, clr_mask;

  assign pipe_win   = pipe_valid && pipe_reg_write && (pipe_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign lu_ready   = !reset && (count != FULL_CNT);
  assign push       = lu_valid && lu_ready;
  // The pipeline is never held back, so the FIFO only drains on idle cycles.
  assign pop        = !reset && !pipe_win && !fifo_empty;
  assign head_rd    = buf_rd[rd_ptr];

  // Scoreboard set/clear masks for this cycle
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_rd != 5'd0)) set_mask[iss_rd] = 1'b1;
    if (pop && (head_rd != 5'd0))      clr_mask[head_rd] = 1'b1;
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[wr_ptr]   <= lu_rd;
      buf_data[wr_ptr] <= lu_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Register-file write port: pipeline first, then FIFO head, else idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd        <= '0;
      rd_din    <= '0;
      reg_write <= 1'b0;
    end else if (pipe_win) begin
      rd        <= pipe_rd;
      rd_din    <= pipe_data;
      reg_write <= 1'b1;
    end else if (pop && (head_rd != 5'd0)) begin
      rd        <= head_rd;
      rd_din    <= buf_data[rd_ptr];
      reg_write <= 1'b1;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Head-of-FIFO wait counter, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset || pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STV_MAX) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Hold-off request: raised once the head has waited long enough, dropped by a pop
  always_ff @(posedge clk) begin
    if (reset || pop) begin
      stall_pipe <= 1'b0;
    end else if (starve_cnt == STV_MAX) begin
      stall_pipe <= 1'b1;
    end
  end

  // Pending scoreboard; a same-cycle set overrides the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_mask <= '0;
    end else begin
      pend_mask <= (pend_mask & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int REG_WIDTH    = 64;
  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 pipe_valid = 1'b0, pipe_reg_write = 1'b0;
  logic [4:0]           pipe_rd = '0;
  logic [REG_WIDTH-1:0] pipe_data = '0;
  logic                 lu_valid = 1'b0;
  logic                 lu_ready;
  logic [4:0]           lu_rd = '0;
  logic [REG_WIDTH-1:0] lu_data = '0;
  logic                 iss_valid = 1'b0;
  logic [4:0]           iss_rd = '0;
  logic [31:0]          pend_mask;
  logic                 stall_pipe;
  logic [4:0]           rd;
  logic [REG_WIDTH-1:0] rd_din;
  logic                 reg_write;

  wb_arbiter #(
    .REG_WIDTH(REG_WIDTH), .BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_reg_write(pipe_reg_write),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .pend_mask(pend_mask), .stall_pipe(stall_pipe),
    .rd(rd), .rd_din(rd_din), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO as a queue, scoreboard as a plain bit vector,
  // starvation as the number of idle-less cycles the current head has waited.
  typedef struct {
    logic [4:0]           rd;
    logic [REG_WIDTH-1:0] data;
  } ent_t;

  ent_t                 m_q[$];
  logic [31:0]          m_pend  = '0;
  logic [4:0]           m_rd    = '0;
  logic [REG_WIDTH-1:0] m_din   = '0;
  logic                 m_we    = 1'b0;
  logic                 m_stall = 1'b0;
  int                   m_wait  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit pv, input bit pw, input logic [4:0] prd,
                      input logic [63:0] pd, input bit lv, input logic [4:0] lrd,
                      input logic [63:0] ld, input bit iv, input logic [4:0] ird);
    ent_t e;
    int   sz;
    bit   win, push, popped;
    @(negedge clk);
    reset = r; pipe_valid = pv; pipe_reg_write = pw; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld; iss_valid = iv; iss_rd = ird;
    #1;
    sz = m_q.size();
    chk("lu_ready", 64'(lu_ready), 64'(!r && (sz < BUF_DEPTH)));
    if (r) begin
      m_q.delete();
      m_pend = '0; m_rd = '0; m_din = '0; m_we = 1'b0; m_wait = 0; m_stall = 1'b0;
    end else begin
      win    = pv && pw && (prd != 5'd0);
      push   = lv && (sz < BUF_DEPTH);
      popped = 1'b0;
      if (win) begin
        m_rd = prd; m_din = pd; m_we = 1'b1;
      end else if (sz > 0) begin
        e = m_q.pop_front();
        popped = 1'b1;
        if (e.rd != 5'd0) begin
          m_rd = e.rd; m_din = e.data; m_we = 1'b1; m_pend[e.rd] = 1'b0;
        end else begin
          m_we = 1'b0;
        end
      end else begin
        m_we = 1'b0;
      end
      if (popped) begin
        m_wait = 0; m_stall = 1'b0;
      end else if (sz == 0) begin
        m_wait = 0;
      end else begin
        if (m_wait >= STARVE_LIMIT) m_stall = 1'b1;
        else m_wait++;
      end
      if (iv && (ird != 5'd0)) m_pend[ird] = 1'b1;
      if (push) m_q.push_back('{rd: lrd, data: ld});
    end
    @(posedge clk);
    #1;
    chk("reg_write", 64'(reg_write), 64'(m_we));
    chk("rd", 64'(rd), 64'(m_rd));
    chk("rd_din", rd_din, m_din);
    chk("pend_mask", 64'(pend_mask), 64'(m_pend));
    chk("stall_pipe", 64'(stall_pipe), 64'(m_stall));
  endtask

  task automatic idle();
    step(0, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0);
  endtask

  task automatic pipe_wr(input logic [4:0] prd, input logic [63:0] pd,
                         input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
    step(0, 1, 1, prd, pd, lv, lrd, ld, 0, 5'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pct;
    bit pv, pw, lv, iv;
    logic [4:0] prd, lrd, ird;

    // Reset for two cycles, then idle
    step(1, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0);
    step(1, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0);
    idle();
    chk("rst_we", 64'(reg_write), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_ready", 64'(lu_ready), 64'd1);

    // Pipeline write lands one cycle later, for one cycle only
    pipe_wr(5'd5, 64'hA5, 0, 5'd0, 64'd0);
    chk("pipe_rd", 64'(rd), 64'd5);
    chk("pipe_din", rd_din, 64'hA5);
    chk("pipe_we", 64'(reg_write), 64'd1);
    idle();
    chk("pipe_we_off", 64'(reg_write), 64'd0);

    // Issue rd=7, then its LU result; write two cycles after acceptance
    step(0, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd7);
    chk("pend7_set", 64'(pend_mask[7]), 64'd1);
    step(0, 0, 0, 5'd0, 64'd0, 1, 5'd7, 64'h1234, 0, 5'd0);
    chk("lu_no_bypass", 64'(reg_write), 64'd0);
    idle();
    chk("lu_we", 64'(reg_write), 64'd1);
    chk("lu_rd", 64'(rd), 64'd7);
    chk("lu_din", rd_din, 64'h1234);
    chk("pend7_clr", 64'(pend_mask[7]), 64'd0);

    // Fill the FIFO while the pipeline wins every cycle, then drain
    pipe_wr(5'd10, 64'h10, 1, 5'd8, 64'h88);
    pipe_wr(5'd11, 64'h11, 1, 5'd9, 64'h99);
    chk("full_ready", 64'(lu_ready), 64'd0);
    for (int i = 0; i < 6; i++) pipe_wr(5'(12 + i), 64'(i), 0, 5'd0, 64'd0);
    chk("starve_stall", 64'(stall_pipe), 64'd1);
    idle();
    chk("drain_rd8", 64'(rd), 64'd8);
    chk("drain_stall", 64'(stall_pipe), 64'd0);
    idle();
    chk("drain_rd9", 64'(rd), 64'd9);
    chk("drain_ready", 64'(lu_ready), 64'd1);

    // x0 pipeline write alongside an LU result
    step(0, 1, 1, 5'd0, 64'hDEAD, 1, 5'd12, 64'hC0, 0, 5'd0);
    chk("x0_we", 64'(reg_write), 64'd0);
    idle();
    chk("x0_pop_rd", 64'(rd), 64'd12);
    chk("x0_pop_we", 64'(reg_write), 64'd1);

    // Reset while one entry is buffered and x3 is pending
    step(0, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd3);
    pipe_wr(5'd20, 64'h20, 1, 5'd3, 64'h33);
    pipe_wr(5'd21, 64'h21, 0, 5'd0, 64'd0);
    chk("pre_rst_pend3", 64'(pend_mask[3]), 64'd1);
    step(1, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0);
    idle();
    chk("post_rst_we", 64'(reg_write), 64'd0);
    chk("post_rst_pend", 64'(pend_mask), 64'd0);

    // Random traffic honouring the upstream rules
    pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) pct = $urandom_range(10, 95);
      pv  = ($urandom_range(0, 99) < pct);
      pw  = ($urandom_range(0, 9) != 0);
      prd = 5'($urandom_range(0, 31));
      if (m_pend[prd]) prd = 5'd0;
      lv  = ($urandom_range(0, 2) == 0);
      lrd = 5'($urandom_range(0, 31));
      iv  = ($urandom_range(0, 3) == 0);
      ird = 5'($urandom_range(0, 31));
      if (m_pend[ird]) iv = 1'b0;
      step(($urandom_range(0, 299) == 0), pv, pw, prd, {$urandom, $urandom},
           lv, lrd, {$urandom, $urandom}, iv, ird);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
